// File: rtl/meas_run_ctrl.sv
// Run sequencer for one MER/error-accumulation window on the 16-QAM test chain.
// Flow: start -> settle (filter flush) -> align to LFSR period boundary
//       -> accumulate N_PERIODS full periods -> latch result -> idle.
// Owns the DAC A source select and holds it steady while a run is in flight.
module meas_run_ctrl #(
    parameter int unsigned N_PERIODS   = 4,
    parameter int unsigned SETTLE_SYMS = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic             start,
    input  logic             abort,
    input  logic             lfsr_cycle,
    input  logic [1:0]       dac_sel_req,
    output logic [1:0]       dac_sel,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             acc_latch,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] period_cnt,
    output logic             start_err
);

    localparam int unsigned      DAC_W       = 2;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SYMS - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(N_PERIODS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_SYNC,
        S_ACCUM,
        S_LATCH
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_cnt_nxt;
    logic [DAC_W-1:0] r_dac_sel,    w_dac_sel_nxt;
    logic             r_acc_clear,  w_acc_clear_nxt;
    logic             r_acc_en,     w_acc_en_nxt;
    logic             r_acc_latch,  w_acc_latch_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_start_err,  w_start_err_nxt;
    logic             w_bnd;

    // LFSR period marker only counts when it coincides with a symbol strobe
    assign w_bnd = lfsr_cycle & sym_clk_ena;

    // Next-state and next-output decode; abort wins over boundary/terminal count
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_period_cnt_nxt = r_period_cnt;
        w_dac_sel_nxt    = r_dac_sel;
        w_acc_clear_nxt  = 1'b0;
        w_acc_latch_nxt  = 1'b0;
        w_start_err_nxt  = start & (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                w_dac_sel_nxt = dac_sel_req;
                if (start && !abort) begin
                    w_state_nxt      = S_SETTLE;
                    w_acc_clear_nxt  = 1'b1;
                    w_settle_cnt_nxt = '0;
                    w_period_cnt_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (sym_clk_ena) begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_nxt = S_WAIT_SYNC;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt + CNT_W'(1);
                    end
                end
            end
            S_WAIT_SYNC: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bnd) begin
                    w_state_nxt      = S_ACCUM;
                    w_period_cnt_nxt = '0;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bnd) begin
                    if (r_period_cnt == PERIOD_LAST) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_period_cnt_nxt = r_period_cnt + CNT_W'(1);
                    end
                end
            end
            S_LATCH: begin
                w_state_nxt     = S_IDLE;
                w_acc_latch_nxt = ~abort;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_acc_en_nxt = (w_state_nxt == S_ACCUM);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
    end

    // State, counters and all outputs registered; synchronous reset
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_period_cnt <= '0;
            r_dac_sel    <= '0;
            r_acc_clear  <= 1'b0;
            r_acc_en     <= 1'b0;
            r_acc_latch  <= 1'b0;
            r_busy       <= 1'b0;
            r_start_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_dac_sel    <= w_dac_sel_nxt;
            r_acc_clear  <= w_acc_clear_nxt;
            r_acc_en     <= w_acc_en_nxt;
            r_acc_latch  <= w_acc_latch_nxt;
            r_busy       <= w_busy_nxt;
            r_start_err  <= w_start_err_nxt;
        end
    end

    assign dac_sel    = r_dac_sel;
    assign acc_clear  = r_acc_clear;
    assign acc_en     = r_acc_en;
    assign acc_latch  = r_acc_latch;
    assign done       = r_acc_latch;
    assign busy       = r_busy;
    assign period_cnt = r_period_cnt;
    assign start_err  = r_start_err;

endmodule

// File: tb/tb_meas_run_ctrl.sv
// Bench for meas_run_ctrl: two instances (N_PERIODS=2 and N_PERIODS=1, SETTLE_SYMS=4)
// share a symbol strobe every 16 clocks and an LFSR boundary every 20 symbols.
// Expected clear/error/done events are queued by the stimulus and consumed by a monitor.
module tb_meas_run_ctrl;

    localparam int unsigned CNT_W    = 16;
    localparam int          BND_SYMS = 20;

    typedef struct {
        int win;
        int pcnt;
    } done_exp_t;

    logic             sys_clk;
    logic             reset;
    logic             sym_clk_ena;
    logic             lfsr_cycle;
    logic [1:0]       dac_sel_req;
    logic             start      [2];
    logic             abort      [2];
    logic [1:0]       dac_sel    [2];
    logic             acc_clear  [2];
    logic             acc_en     [2];
    logic             acc_latch  [2];
    logic             done       [2];
    logic             busy       [2];
    logic             start_err  [2];
    logic [CNT_W-1:0] period_cnt [2];

    int        checks   = 0;
    int        failures = 0;
    int        exp_clr  [2];
    int        exp_err  [2];
    int        win      [2];
    done_exp_t q_done0  [$];
    done_exp_t q_done1  [$];
    int        phase = 0;
    int        sidx  = 0;

    meas_run_ctrl #(.N_PERIODS(2), .SETTLE_SYMS(4), .CNT_W(CNT_W)) u_dut0 (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_ena(sym_clk_ena),
        .start(start[0]), .abort(abort[0]), .lfsr_cycle(lfsr_cycle),
        .dac_sel_req(dac_sel_req), .dac_sel(dac_sel[0]), .acc_clear(acc_clear[0]),
        .acc_en(acc_en[0]), .acc_latch(acc_latch[0]), .done(done[0]), .busy(busy[0]),
        .period_cnt(period_cnt[0]), .start_err(start_err[0])
    );

    meas_run_ctrl #(.N_PERIODS(1), .SETTLE_SYMS(4), .CNT_W(CNT_W)) u_dut1 (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_ena(sym_clk_ena),
        .start(start[1]), .abort(abort[1]), .lfsr_cycle(lfsr_cycle),
        .dac_sel_req(dac_sel_req), .dac_sel(dac_sel[1]), .acc_clear(acc_clear[1]),
        .acc_en(acc_en[1]), .acc_latch(acc_latch[1]), .done(done[1]), .busy(busy[1]),
        .period_cnt(period_cnt[1]), .start_err(start_err[1])
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Symbol strobe on phase 15; lfsr_cycle held high across the whole boundary symbol
    initial begin
        sym_clk_ena = 1'b0;
        lfsr_cycle  = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (phase == 15) begin
                phase = 0;
                sidx++;
            end else begin
                phase++;
            end
            sym_clk_ena = (phase == 15);
            lfsr_cycle  = ((sidx % BND_SYMS) == BND_SYMS - 1);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon_inst(input int i);
        done_exp_t e;
        logic      have;
        e    = '{win: 0, pcnt: 0};
        have = 1'b0;
        if (acc_clear[i]) begin
            chk($sformatf("clear_expected%0d", i), (exp_clr[i] > 0) ? 1 : 0, 1);
            if (exp_clr[i] > 0) exp_clr[i]--;
            chk($sformatf("clear_busy%0d", i), int'(busy[i]), 1);
            chk($sformatf("clear_pcnt%0d", i), int'(period_cnt[i]), 0);
            win[i] = 0;
        end
        if (acc_en[i] && sym_clk_ena) win[i]++;
        if (acc_latch[i] || done[i]) begin
            chk($sformatf("latch_eq_done%0d", i), int'(acc_latch[i]), int'(done[i]));
            if (i == 0) begin
                if (q_done0.size() > 0) begin
                    e    = q_done0.pop_front();
                    have = 1'b1;
                end
            end else begin
                if (q_done1.size() > 0) begin
                    e    = q_done1.pop_front();
                    have = 1'b1;
                end
            end
            chk($sformatf("done_expected%0d", i), int'(have), 1);
            if (have) begin
                chk($sformatf("window_len%0d", i), win[i], e.win);
                chk($sformatf("final_pcnt%0d", i), int'(period_cnt[i]), e.pcnt);
            end
        end
        if (start_err[i]) begin
            chk($sformatf("start_err_expected%0d", i), (exp_err[i] > 0) ? 1 : 0, 1);
            if (exp_err[i] > 0) exp_err[i]--;
        end
    endtask

    // Monitor: consumes expected events whenever the DUTs present a pulse
    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_clr[i] = 0;
            exp_err[i] = 0;
            win[i]     = 0;
        end
        forever begin
            @(negedge sys_clk);
            if (!reset) begin
                for (int i = 0; i < 2; i++) mon_inst(i);
            end
        end
    end

    task automatic push_done(input int i, input int w, input int p);
        done_exp_t e;
        e = '{win: w, pcnt: p};
        if (i == 0) q_done0.push_back(e);
        else        q_done1.push_back(e);
    endtask

    // Leaves the caller at posedge+2 of phase 0 of a symbol with sidx%20 == m
    task automatic wait_sym(input int m);
        int n;
        n = 0;
        do begin
            @(posedge sys_clk);
            #2;
            n++;
        end while (!(((sidx % BND_SYMS) == m) && (phase == 0)) && n < 800);
        chk($sformatf("sym_align_%0d", m), (n < 800) ? 1 : 0, 1);
    endtask

    // what: 0 done, 1 acc_en high, 2 acc_en low, 3 boundary, 4 symbol strobe
    task automatic wait_out(input int i, input int what, input string nm);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 3000) begin
            @(negedge sys_clk);
            n++;
            case (what)
                0:       hit = done[i];
                1:       hit = acc_en[i];
                2:       hit = !acc_en[i];
                3:       hit = sym_clk_ena && lfsr_cycle;
                4:       hit = sym_clk_ena;
                default: hit = 1'b1;
            endcase
        end
        chk(nm, int'(hit), 1);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(posedge sys_clk);
        #2;
        start[i] = 1'b0;
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk($sformatf("%s_dac_sel%0d", tag, i),   int'(dac_sel[i]),    0);
        chk($sformatf("%s_acc_clear%0d", tag, i), int'(acc_clear[i]),  0);
        chk($sformatf("%s_acc_en%0d", tag, i),    int'(acc_en[i]),     0);
        chk($sformatf("%s_acc_latch%0d", tag, i), int'(acc_latch[i]),  0);
        chk($sformatf("%s_done%0d", tag, i),      int'(done[i]),       0);
        chk($sformatf("%s_busy%0d", tag, i),      int'(busy[i]),       0);
        chk($sformatf("%s_start_err%0d", tag, i), int'(start_err[i]),  0);
        chk($sformatf("%s_pcnt%0d", tag, i),      int'(period_cnt[i]), 0);
    endtask

    task automatic run_normal(input int i, input int w, input int p);
        wait_sym(5);
        exp_clr[i]++;
        push_done(i, w, p);
        pulse_start(i);
        @(negedge sys_clk);
        chk($sformatf("start_clear%0d", i), int'(acc_clear[i]), 1);
        chk($sformatf("start_busy%0d", i),  int'(busy[i]),      1);
        wait_out(i, 0, $sformatf("run_done_seen%0d", i));
        chk($sformatf("done_busy%0d", i), int'(busy[i]), 0);
        @(negedge sys_clk);
        chk($sformatf("after_busy%0d", i),  int'(busy[i]),       0);
        chk($sformatf("after_pcnt%0d", i),  int'(period_cnt[i]), p);
        chk($sformatf("after_done%0d", i),  int'(done[i]),       0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        dac_sel_req = 2'd3;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end

        // Power-up reset state
        repeat (3) @(negedge sys_clk);
        chk_zero(0, "por");
        chk_zero(1, "por");
        @(posedge sys_clk);
        #2;
        reset       = 1'b0;
        dac_sel_req = 2'd1;

        // start & abort together in IDLE: ignored, no error
        @(posedge sys_clk);
        #2;
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge sys_clk);
        #2;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        @(negedge sys_clk);
        chk("start_abort_busy",  int'(busy[0]),      0);
        chk("start_abort_clear", int'(acc_clear[0]), 0);
        chk("start_abort_err",   int'(start_err[0]), 0);
        chk("idle_dac_track",    int'(dac_sel[0]),   1);

        // Normal run: 2 periods of 20 symbols
        run_normal(0, 40, 1);

        // start during WAIT_SYNC rejected; window unaffected
        wait_sym(5);
        exp_clr[0]++;
        push_done(0, 40, 1);
        pulse_start(0);
        wait_sym(12);
        exp_err[0]++;
        pulse_start(0);
        wait_out(0, 0, "ws_done_seen");

        // abort 5 symbols into ACCUM; then a normal run
        wait_sym(5);
        exp_clr[0]++;
        pulse_start(0);
        wait_out(0, 1, "ab_acc_en_rise");
        repeat (5) wait_out(0, 4, "ab_sym");
        chk("ab_acc_en_before", int'(acc_en[0]), 1);
        abort[0] = 1'b1;
        @(posedge sys_clk);
        #2;
        abort[0] = 1'b0;
        @(negedge sys_clk);
        chk("ab_acc_en", int'(acc_en[0]), 0);
        chk("ab_busy",   int'(busy[0]),   0);
        repeat (1200) @(negedge sys_clk);
        run_normal(0, 40, 1);

        // dac_sel frozen across run; start in LATCH cycle rejected
        wait_sym(5);
        exp_clr[0]++;
        push_done(0, 40, 1);
        pulse_start(0);
        wait_out(0, 1, "dac_acc_en_rise");
        dac_sel_req = 2'd2;
        repeat (3) @(negedge sys_clk);
        chk("dac_frozen_accum", int'(dac_sel[0]), 1);
        wait_out(0, 2, "dac_acc_en_fall");
        chk("dac_frozen_latch", int'(dac_sel[0]), 1);
        exp_err[0]++;
        start[0] = 1'b1;
        @(posedge sys_clk);
        #2;
        start[0] = 1'b0;
        @(negedge sys_clk);
        chk("latch_cyc_done",   int'(done[0]),    1);
        chk("dac_at_done",      int'(dac_sel[0]), 1);
        chk("latch_cyc_busy",   int'(busy[0]),    0);
        @(negedge sys_clk);
        chk("dac_resumed",      int'(dac_sel[0]),   2);
        chk("latch_start_busy", int'(busy[0]),      0);
        chk("latch_start_clr",  int'(acc_clear[0]), 0);

        // reset mid-ACCUM after the first period completed
        wait_sym(5);
        exp_clr[0]++;
        pulse_start(0);
        wait_out(0, 1, "rst_acc_en_rise");
        repeat (25) wait_out(0, 4, "rst_sym");
        chk("rst_pcnt_before", int'(period_cnt[0]), 1);
        reset = 1'b1;
        @(negedge sys_clk);
        chk_zero(0, "midrst");
        repeat (2) @(negedge sys_clk);
        @(posedge sys_clk);
        #2;
        reset = 1'b0;

        // N_PERIODS=1: normal single window, then abort on the terminal boundary
        run_normal(1, 20, 0);
        wait_sym(5);
        exp_clr[1]++;
        pulse_start(1);
        wait_out(1, 1, "n1_acc_en_rise");
        wait_out(1, 3, "n1_term_bnd");
        chk("n1_acc_en_before", int'(acc_en[1]), 1);
        abort[1] = 1'b1;
        @(posedge sys_clk);
        #2;
        abort[1] = 1'b0;
        @(negedge sys_clk);
        chk("n1_ab_acc_en", int'(acc_en[1]),    0);
        chk("n1_ab_busy",   int'(busy[1]),      0);
        chk("n1_ab_latch",  int'(acc_latch[1]), 0);
        repeat (40) @(negedge sys_clk);

        // Every queued expectation must have been consumed
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pending_clear%0d", i), exp_clr[i], 0);
            chk($sformatf("pending_err%0d", i),   exp_err[i], 0);
        end
        chk("pending_done0", q_done0.size(), 0);
        chk("pending_done1", q_done1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
